// File: rtl/router_sync_n_if.sv
// Bundles the FSM-side strobes, the FIFO flags and the synchroniser outputs of the 1xN router.
// The master modport belongs to whatever drives the synchroniser; the slave modport belongs to the synchroniser itself.
interface router_sync_n_if #(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_W    = 2
);
   logic                 detect_add;
   logic [ADDR_W-1:0]    addr_in;
   logic                 write_enb_reg;
   logic [NUM_PORTS-1:0] read_enb;
   logic [NUM_PORTS-1:0] empty;
   logic [NUM_PORTS-1:0] full;
   logic [NUM_PORTS-1:0] vld_out;
   logic [NUM_PORTS-1:0] write_enb;
   logic                 fifo_full;
   logic [NUM_PORTS-1:0] soft_reset;
   logic [ADDR_W-1:0]    dest;
   logic                 addr_err;

   modport master (
      output detect_add, addr_in, write_enb_reg, read_enb, empty, full,
      input  vld_out, write_enb, fifo_full, soft_reset, dest, addr_err
   );

   modport slave (
      input  detect_add, addr_in, write_enb_reg, read_enb, empty, full,
      output vld_out, write_enb, fifo_full, soft_reset, dest, addr_err
   );
endinterface

// File: rtl/router_sync_n.sv
// Port synchroniser for the 1xN router: latches the destination, steers writes and full flags,
// and raises a per-port soft reset after TIMEOUT consecutive stalled cycles.
module router_sync_n #(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_W    = 2,
   parameter int TIMEOUT   = 30,
   parameter int CNT_W     = 8
) (
   input logic             clk,
   input logic             resetn,
   router_sync_n_if.slave  bus
);

   localparam logic [ADDR_W:0]  NPORTS = (ADDR_W+1)'(NUM_PORTS);
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(TIMEOUT - 1);

   logic [ADDR_W-1:0]    dest_q;
   logic                 addr_err_q;
   logic [NUM_PORTS-1:0] soft_reset_q;
   logic [NUM_PORTS-1:0] stall;
   logic [NUM_PORTS-1:0] write_enb_c;
   logic                 fifo_full_c;
   logic [CNT_W-1:0]     cnt [NUM_PORTS];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         dest_q     <= '0;
         addr_err_q <= 1'b0;
      end else if (bus.detect_add) begin
         dest_q     <= bus.addr_in;
         addr_err_q <= ({1'b0, bus.addr_in} >= NPORTS);
      end
   end

   // Decode uses only the registered dest, so a same-cycle detect_add cannot redirect a write.
   always_comb begin
      write_enb_c = '0;
      fifo_full_c = 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (!addr_err_q && dest_q == ADDR_W'(i)) begin
            write_enb_c[i] = bus.write_enb_reg;
            fifo_full_c    = bus.full[i];
         end
      end
   end

   assign stall = ~bus.empty & ~bus.read_enb;

   // Counter reloads on reaching TIMEOUT-1, so it can never wrap.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
         soft_reset_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!stall[i]) begin
               cnt[i]          <= '0;
               soft_reset_q[i] <= 1'b0;
            end else if (cnt[i] == LAST) begin
               cnt[i]          <= '0;
               soft_reset_q[i] <= 1'b1;
            end else begin
               cnt[i]          <= cnt[i] + 1'b1;
               soft_reset_q[i] <= 1'b0;
            end
         end
      end
   end

   assign bus.vld_out    = ~bus.empty;
   assign bus.write_enb  = write_enb_c;
   assign bus.fifo_full  = fifo_full_c;
   assign bus.soft_reset = soft_reset_q;
   assign bus.dest       = dest_q;
   assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n with NUM_PORTS=3, TIMEOUT=30: steering, bad address and stall timeouts.
// Inputs change 1 time unit after a rising edge and outputs are sampled there as well.
module tb_router_sync_n;

   logic clk;
   logic resetn;
   int   total;
   int   bad;

   router_sync_n_if #(.NUM_PORTS(3), .ADDR_W(2)) bus ();

   router_sync_n #(.NUM_PORTS(3), .ADDR_W(2), .TIMEOUT(30), .CNT_W(8)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.detect_add    = 1'b0;
      bus.addr_in       = 2'd0;
      bus.write_enb_reg = 1'b0;
      bus.read_enb      = 3'b000;
      bus.empty         = 3'b111;
      bus.full          = 3'b000;
   endtask

   task automatic test_reset();
      idle();
      resetn = 1'b0;
      bus.empty = 3'b101;
      tick();
      total++;
      if (bus.dest !== 2'd0) begin bad++; $display("FAIL reset_dest got=%0d want=0", bus.dest); end
      total++;
      if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b want=0", bus.addr_err); end
      total++;
      if (bus.soft_reset !== 3'b000) begin bad++; $display("FAIL reset_soft_reset got=%b want=000", bus.soft_reset); end
      total++;
      if (bus.vld_out !== 3'b010) begin bad++; $display("FAIL reset_vld_out got=%b want=010", bus.vld_out); end
      total++;
      if (bus.write_enb !== 3'b000) begin bad++; $display("FAIL reset_wen_idle got=%b want=000", bus.write_enb); end
      bus.write_enb_reg = 1'b1;
      #1;
      total++;
      if (bus.write_enb !== 3'b001) begin bad++; $display("FAIL reset_wen_req got=%b want=001", bus.write_enb); end
      idle();
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_steering();
      bus.detect_add    = 1'b1;
      bus.addr_in       = 2'd2;
      bus.write_enb_reg = 1'b1;
      #1;
      total++;
      if (bus.write_enb !== 3'b001) begin bad++; $display("FAIL steer_same_cycle got=%b want=001", bus.write_enb); end
      tick();
      bus.detect_add = 1'b0;
      #1;
      total++;
      if (bus.dest !== 2'd2) begin bad++; $display("FAIL steer_dest got=%0d want=2", bus.dest); end
      total++;
      if (bus.write_enb !== 3'b100) begin bad++; $display("FAIL steer_wen got=%b want=100", bus.write_enb); end
      total++;
      if (bus.fifo_full !== 1'b0) begin bad++; $display("FAIL steer_full_clear got=%b want=0", bus.fifo_full); end
      bus.full = 3'b100;
      #1;
      total++;
      if (bus.fifo_full !== 1'b1) begin bad++; $display("FAIL steer_full_set got=%b want=1", bus.fifo_full); end
      bus.full = 3'b011;
      #1;
      total++;
      if (bus.fifo_full !== 1'b0) begin bad++; $display("FAIL steer_full_other got=%b want=0", bus.fifo_full); end
      bus.write_enb_reg = 1'b0;
      #1;
      total++;
      if (bus.write_enb !== 3'b000) begin bad++; $display("FAIL steer_wen_off got=%b want=000", bus.write_enb); end
      idle();
      tick();
   endtask

   task automatic test_bad_addr();
      bus.detect_add = 1'b1;
      bus.addr_in    = 2'd3;
      tick();
      bus.detect_add    = 1'b0;
      bus.write_enb_reg = 1'b1;
      bus.full          = 3'b111;
      #1;
      total++;
      if (bus.addr_err !== 1'b1) begin bad++; $display("FAIL bad_addr_err got=%b want=1", bus.addr_err); end
      total++;
      if (bus.write_enb !== 3'b000) begin bad++; $display("FAIL bad_addr_wen got=%b want=000", bus.write_enb); end
      total++;
      if (bus.fifo_full !== 1'b0) begin bad++; $display("FAIL bad_addr_full got=%b want=0", bus.fifo_full); end
      tick();
      total++;
      if (bus.addr_err !== 1'b1) begin bad++; $display("FAIL bad_addr_hold got=%b want=1", bus.addr_err); end
      bus.detect_add = 1'b1;
      bus.addr_in    = 2'd0;
      tick();
      bus.detect_add = 1'b0;
      #1;
      total++;
      if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL bad_addr_clear got=%b want=0", bus.addr_err); end
      total++;
      if (bus.write_enb !== 3'b001) begin bad++; $display("FAIL bad_addr_recover_wen got=%b want=001", bus.write_enb); end
      total++;
      if (bus.fifo_full !== 1'b1) begin bad++; $display("FAIL bad_addr_recover_full got=%b want=1", bus.fifo_full); end
      idle();
      tick();
   endtask

   task automatic test_timeout();
      logic [2:0] exp;
      bus.empty    = 3'b101;
      bus.read_enb = 3'b000;
      for (int k = 0; k < 65; k++) begin
         tick();
         exp = (k == 29 || k == 59) ? 3'b010 : 3'b000;
         total++;
         if (bus.soft_reset !== exp) begin
            bad++;
            $display("FAIL timeout_edge%0d got=%b want=%b", k, bus.soft_reset, exp);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_independent();
      logic [2:0] exp;
      bus.empty = 3'b000;
      for (int k = 0; k < 41; k++) begin
         bus.read_enb[0] = 1'b0;
         bus.read_enb[1] = (k % 2 == 0);
         bus.read_enb[2] = (k < 5);
         tick();
         exp = 3'b000;
         if (k == 29) exp[0] = 1'b1;
         if (k == 34) exp[2] = 1'b1;
         total++;
         if (bus.soft_reset !== exp) begin
            bad++;
            $display("FAIL indep_edge%0d got=%b want=%b", k, bus.soft_reset, exp);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_restart();
      logic [2:0] exp;
      bus.empty = 3'b110;
      for (int k = 0; k < 66; k++) begin
         bus.read_enb = (k == 29) ? 3'b001 : 3'b000;
         tick();
         exp = (k == 59) ? 3'b001 : 3'b000;
         total++;
         if (bus.soft_reset !== exp) begin
            bad++;
            $display("FAIL restart_edge%0d got=%b want=%b", k, bus.soft_reset, exp);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_reset_mid();
      logic [2:0] exp;
      bus.detect_add = 1'b1;
      bus.addr_in    = 2'd3;
      tick();
      bus.detect_add = 1'b0;
      #1;
      total++;
      if (bus.addr_err !== 1'b1 || bus.dest !== 2'd3) begin
         bad++;
         $display("FAIL rstmid_setup got=%b/%0d want=1/3", bus.addr_err, bus.dest);
      end
      bus.empty    = 3'b110;
      bus.read_enb = 3'b000;
      for (int k = 0; k < 56; k++) begin
         resetn = (k == 20) ? 1'b0 : 1'b1;
         tick();
         exp = (k == 50) ? 3'b001 : 3'b000;
         total++;
         if (bus.soft_reset !== exp) begin
            bad++;
            $display("FAIL rstmid_edge%0d got=%b want=%b", k, bus.soft_reset, exp);
         end
         if (k == 20) begin
            total++;
            if (bus.dest !== 2'd0) begin bad++; $display("FAIL rstmid_dest got=%0d want=0", bus.dest); end
            total++;
            if (bus.addr_err !== 1'b0) begin bad++; $display("FAIL rstmid_addr_err got=%b want=0", bus.addr_err); end
         end
      end
      resetn = 1'b1;
      idle();
      tick();
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      resetn = 1'b0;
      idle();
      test_reset();
      test_steering();
      test_bad_addr();
      test_timeout();
      test_independent();
      test_restart();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
